// File: rtl/sort_pkg.sv
// Shared defaults and FSM encoding for the sorted array serializer.
// Imported by the top module and the order checker.
package sort_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sorted_array_serializer_order_checker.sv
// Remembers the last transferred element and flags any descent.
// Clear zeroes the history, so the first element can never trip it.
module order_checker
  import sort_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         valid_xfer,
  input  logic [W-1:0] data,
  output logic         err
);

  logic [W-1:0] prev;

  // track previous value and set the sticky flag on a strict decrease
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev <= '0;
      err  <= 1'b0;
    end else if (valid_xfer) begin
      prev <= data;
      if (data < prev) err <= 1'b1;
    end
  end

endmodule

// File: rtl/sorted_array_serializer.sv
// Captures an N-element array and streams it out over valid/ready,
// flagging arrays whose elements are not in ascending order.
module sorted_array_serializer
  import sort_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic [N*W-1:0]                  arr_in,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [W-1:0]                    out_data,
  output logic [(N>1?$clog2(N):1)-1:0]    out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            order_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  buffer [N];
  logic          accept;
  logic          xfer;
  logic          at_last;

  assign accept  = (state == IDLE) && load;
  assign xfer    = out_valid && out_ready;
  assign at_last = (idx == LAST);

  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_data  = out_valid ? buffer[idx] : '0;
  assign out_index = out_valid ? idx : '0;
  assign out_last  = out_valid && at_last;

  // buffer capture only on an accepted load; contents are never reset
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      for (int i = 0; i < N; i++) buffer[i] <= arr_in[i*W +: W];
    end
  end

  // FSM and element index; idx parks at N-1 instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (at_last) state <= DONE;
            else         idx   <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  order_checker #(.W(W)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .valid_xfer (xfer),
    .data       (out_data),
    .err        (order_err)
  );

endmodule

// File: tb/tb_sorted_array_serializer.sv
// Directed bench for sorted_array_serializer (N=8, W=8).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_sorted_array_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] arr_in;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        order_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sorted_array_serializer #(.N(8), .W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .arr_in    (arr_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .order_err (order_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] e [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  task automatic do_load(input logic [7:0] e [8]);
    arr_in = pack(e);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // stream with ready high from element `from`, then check DONE and IDLE
  task automatic drain(input string tag, input logic [7:0] e [8],
                       input int from, input logic err_exp);
    out_ready = 1'b1;
    for (int i = from; i < 8; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(e[i]));
      chk({tag, "_index"}, 32'(out_index), 32'(i));
      chk({tag, "_last"},  32'(out_last),  32'(i == 7));
      step();
    end
    chk({tag, "_done"},     32'(done),      32'd1);
    chk({tag, "_dvalid"},   32'(out_valid), 32'd0);
    chk({tag, "_dbusy"},    32'(busy),      32'd1);
    chk({tag, "_derr"},     32'(order_err), 32'(err_exp));
    step();
    chk({tag, "_idone"},    32'(done),      32'd0);
    chk({tag, "_ibusy"},    32'(busy),      32'd0);
    chk({tag, "_ierr"},     32'(order_err), 32'(err_exp));
  endtask

  logic [7:0] asc [8] = '{8'h00, 8'h01, 8'h02, 8'h03,
                          8'h04, 8'h05, 8'h06, 8'h07};
  logic [7:0] bad [8] = '{8'h00, 8'h01, 8'h02, 8'h40,
                          8'h10, 8'h05, 8'h06, 8'h07};
  logic [7:0] flat [8] = '{default: 8'h55};
  logic [7:0] other [8] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3,
                            8'hF4, 8'hF5, 8'hF6, 8'hF7};
  logic [7:0] early [8] = '{8'h00, 8'h40, 8'h10, 8'h20,
                            8'h30, 8'h50, 8'h60, 8'h70};

  initial begin
    int cnt;
    reset = 1'b1;
    load = 1'b0;
    arr_in = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(order_err), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    reset = 1'b0;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // ascending array, ready held high
    out_ready = 1'b1;
    do_load(asc);
    drain("asc", asc, 0, 1'b0);

    // ready toggling: each element held while ready is low
    do_load(asc);
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b0;
      step();
      chk("tog_hold_valid", 32'(out_valid), 32'd1);
      chk("tog_hold_data",  32'(out_data),  32'(asc[i]));
      chk("tog_hold_index", 32'(out_index), 32'(i));
      chk("tog_hold_last",  32'(out_last),  32'(i == 7));
      out_ready = 1'b1;
      step();
    end
    chk("tog_done", 32'(done), 32'd1);
    step();
    chk("tog_idle", 32'(busy), 32'd0);

    // descent at index 4
    do_load(bad);
    for (int i = 0; i < 4; i++) step();
    chk("bad_pre_err", 32'(order_err), 32'd0);
    chk("bad_idx4",    32'(out_data),  32'h10);
    step();
    chk("bad_post_err", 32'(order_err), 32'd1);
    drain("bad", bad, 5, 1'b1);
    step();
    chk("bad_idle_err", 32'(order_err), 32'd1);
    do_load(asc);
    chk("bad_clr_err", 32'(order_err), 32'd0);
    drain("clr", asc, 0, 1'b0);

    // equal values never flag; count transfers with a cycle budget
    do_load(flat);
    cnt = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (out_valid && out_ready) cnt++;
      step();
    end
    chk("flat_done", 32'(done),      32'd1);
    chk("flat_cnt",  32'(cnt),       32'd8);
    chk("flat_err",  32'(order_err), 32'd0);
    step();

    // second load mid-stream is ignored
    do_load(asc);
    chk("ign_d0", 32'(out_data), 32'(asc[0]));
    arr_in = pack(other);
    load = 1'b1;
    step();
    load = 1'b0;
    drain("ign", asc, 1, 1'b0);

    // reset after three transfers, with the error flag already set
    do_load(early);
    step();
    step();
    step();
    chk("rs_err_set", 32'(order_err), 32'd1);
    chk("rs_idx3",    32'(out_index), 32'd3);
    reset = 1'b1;
    step();
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_busy",  32'(busy),      32'd0);
    chk("rs_err",   32'(order_err), 32'd0);
    chk("rs_data",  32'(out_data),  32'd0);
    reset = 1'b0;
    step();
    chk("rs_quiet", 32'(out_valid), 32'd0);
    do_load(asc);
    drain("rs_new", asc, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/sorted_array_serializer.md
SORTED_ARRAY_SERIALIZER -- requirements
Module: sorted_array_serializer

Interface
REQ-001 The block SHALL have parameter N, default 8, the number of elements per array.
REQ-002 The block SHALL have parameter W, default 8, the element width in bits.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port load, input, 1 bit, SHALL request capture of arr_in.
REQ-006 Port arr_in, input, N*W bits, SHALL carry the array; element i SHALL be arr_in[i*W +: W].
REQ-007 Port out_valid, output, 1 bit, SHALL flag that out_data holds an element.
REQ-008 Port out_ready, input, 1 bit, SHALL be the consumer's acceptance signal.
REQ-009 Port out_data, output, W bits, SHALL carry the current element.
REQ-010 Port out_index, output, clog2(N) bits, SHALL carry the index of the current element.
REQ-011 Port out_last, output, 1 bit, SHALL flag element N-1.
REQ-012 Port busy, output, 1 bit, SHALL be high in SEND and DONE.
REQ-013 Port done, output, 1 bit, SHALL pulse for exactly one cycle after the final transfer.
REQ-014 Port order_err, output, 1 bit, SHALL be a sticky flag marking a non-ascending sequence in the current array.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-016 In IDLE, a load sampled high SHALL capture arr_in into an internal buffer, clear idx and order_err, and enter SEND on the same edge.
REQ-017 A load asserted in SEND or DONE SHALL be ignored, and the buffer SHALL stay unchanged.
REQ-018 out_valid SHALL be high only in SEND, so the first element appears one cycle after the load edge.
REQ-019 A transfer SHALL occur on each edge where out_valid and out_ready are both high.
REQ-020 Each transfer SHALL advance idx by 1.
REQ-021 A transfer with idx equal to N-1 SHALL move the FSM to DONE.
REQ-022 out_data, out_index and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 out_data SHALL equal buffer[idx], out_index SHALL equal idx, and out_last SHALL equal (idx == N-1) and out_valid.
REQ-024 With out_ready held high, all N transfers SHALL complete in N consecutive cycles; DONE SHALL follow for one cycle, then IDLE.
REQ-025 done SHALL be high only in the DONE state.
REQ-026 DONE SHALL return to IDLE unconditionally.
REQ-027 For each transfer with idx greater than 0 whose value is less than the previously transferred value (unsigned compare), order_err SHALL be set.
REQ-028 Equal adjacent values SHALL NOT set order_err.
REQ-029 order_err SHALL hold its value through DONE and IDLE until the next accepted load clears it.
REQ-030 When out_valid is low, out_data, out_index and out_last SHALL be driven to 0.
REQ-031 idx SHALL NOT wrap; no transfer SHALL be possible beyond N-1.

Reset
REQ-032 While reset is high, the FSM SHALL enter IDLE, and idx, the previous-value register and order_err SHALL clear to 0.
REQ-033 While reset is high, out_valid, busy, done and order_err SHALL read 0 from the next edge onward.
REQ-034 Reset SHALL take priority over load and over any transfer on the same edge.
REQ-035 A reset during SEND SHALL abandon the array; no further element SHALL be emitted.
REQ-036 Buffer contents need not be reset.

Structure
REQ-037 The N and W defaults and the IDLE/SEND/DONE state encoding SHALL live in the shared package sort_pkg.
REQ-038 The previous-value register and comparator SHALL form one sub-module, order_checker, with inputs clk, reset, clear, valid_xfer and data, and output err.
REQ-039 The buffer, idx counter and FSM SHALL remain in the top module.

Verification
REQ-040 Load arr_in = {8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01,8'h00} (element 0 = 0x00) with out_ready=1 -> out_data 0x00..0x07 on 8 consecutive cycles; out_last on 0x07; done one cycle later; order_err=0.
REQ-041 Same array with out_ready toggling 1,0,1,0 -> each element held stable while ready=0; 8 transfers total, no duplicates or skips.
REQ-042 Elements 3 and 4 = 0x40, 0x10, rest ascending -> order_err rises after transfer of index 4 and stays high through IDLE; the next load clears it.
REQ-043 All elements = 0x55 -> order_err stays 0 and 8 transfers occur.
REQ-044 Second load pulsed during SEND with a different array -> ignored; the first array is emitted intact.
REQ-045 Reset asserted after 3 transfers -> next cycle out_valid=0, busy=0, order_err=0; a fresh load restarts from index 0.
